// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// pc_pkg : next-PC select encodings and default PC/vector constants
// Revision: 1.0
// ============================================================================
package pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_JMP = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/pc_next_unit_if.sv
`default_nettype none
// ============================================================================
// pc_next_unit_if : control/operand inputs and PC outputs of the PC stage
// Revision: 1.0
// ============================================================================
interface pc_next_unit_if #(
  parameter int W = 32
);
  import pc_pkg::*;

  logic           stall;
  npc_sel_e       npc_sel;
  logic           br_taken;
  logic [15:0]    imm16;
  logic [W-7:0]   target;
  logic [W-1:0]   rs_val;
  logic           link;
  logic           ret;
  logic [W-1:0]   pc;
  logic [W-1:0]   pc_plus4;
  logic           ras_miss;
  logic           misalign;

  modport master (
    output stall, npc_sel, br_taken, imm16, target, rs_val, link, ret,
    input  pc, pc_plus4, ras_miss, misalign
  );

  modport slave (
    input  stall, npc_sel, br_taken, imm16, target, rs_val, link, ret,
    output pc, pc_plus4, ras_miss, misalign
  );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : circular return-address stack with saturating count; flags a
//          popped return whose target disagrees with the stacked address.
// Revision: 1.0
// ============================================================================
module pc_ras #(
  parameter int W         = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  input  logic [W-1:0] cmp_data,
  output logic         miss
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [W-1:0]     mem_q [RAS_DEPTH];
  logic [W-1:0]     mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_q, miss_d;

  always_comb begin
    mem_d  = mem_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    miss_d = pop && ((cnt_q == '0) || (mem_q[top_q] != cmp_data));
    if (push && pop) begin
      // Call-through-return: old top is checked, then replaced in place.
      mem_d[top_q] = push_data;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (push) begin
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = push_data;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  // Entry contents carry no reset value; count gates their validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign miss = miss_q;

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// pc_next_unit : PC register and next-PC selection (seq/branch/jump/jr) with
//                return-address checking and misaligned-JR trapping.
// Revision: 1.0
// ============================================================================
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_PC  = W'(DEF_RESET_PC),
  parameter logic [W-1:0] EXC_VEC   = W'(DEF_EXC_VEC),
  parameter int           RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_next_unit_if.slave   bus
);
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] br_offset;
  logic [W-1:0] br_target;
  logic [W-1:0] jmp_target;
  logic [W-1:0] next_pc;
  logic         jr_misaligned;
  logic         misalign_q, misalign_d;
  logic         ras_push;
  logic         ras_pop;

  assign pc_plus4      = pc_q + W'(4);
  assign br_offset     = W'($signed(bus.imm16)) << 2;
  assign br_target     = pc_plus4 + br_offset;
  assign jmp_target    = {pc_plus4[W-1:W-4], bus.target, 2'b00};
  assign jr_misaligned = (bus.rs_val[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    case (bus.npc_sel)
      NPC_SEQ: next_pc = pc_plus4;
      NPC_BR:  next_pc = bus.br_taken ? br_target : pc_plus4;
      NPC_JMP: next_pc = jmp_target;
      NPC_JR:  next_pc = jr_misaligned ? EXC_VEC : bus.rs_val;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d       = bus.stall ? pc_q : next_pc;
    misalign_d = !bus.stall && (bus.npc_sel == NPC_JR) && jr_misaligned;
    ras_push   = !bus.stall && bus.link &&
                 ((bus.npc_sel == NPC_JMP) || (bus.npc_sel == NPC_JR));
    ras_pop    = !bus.stall && bus.ret && (bus.npc_sel == NPC_JR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // The RAS only checks predictions; the architectural target stays rs_val.
  pc_ras #(
    .W         (W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .cmp_data  (bus.rs_val),
    .miss      (bus.ras_miss)
  );

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_next_unit : directed vector table plus RAS / reset corner sequences
// Revision: 1.0
// ============================================================================
module tb_pc_next_unit;
  import pc_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_next_unit_if #(.W(W)) bus ();

  pc_next_unit #(
    .W         (W),
    .RESET_PC  (32'h0000_0000),
    .EXC_VEC   (32'h0000_0080),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic        lk;
    logic        rt;
    logic        st;
    logic [31:0] exp_pc;
    logic        exp_miss;
    logic        exp_mis;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic [1:0] sel, logic bt, logic [15:0] imm, logic [25:0] tgt,
                              logic [31:0] rs, logic lk, logic rt, logic st,
                              logic [31:0] exp_pc, logic exp_miss, logic exp_mis);
    vec_t v;
    v.sel = sel; v.bt = bt; v.imm = imm; v.tgt = tgt; v.rs = rs;
    v.lk = lk; v.rt = rt; v.st = st;
    v.exp_pc = exp_pc; v.exp_miss = exp_miss; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] p, input logic m, input logic ma);
    chk({tag, " pc"}, bus.pc, p);
    chk({tag, " pc_plus4"}, bus.pc_plus4, p + 32'd4);
    chk({tag, " ras_miss"}, {31'd0, bus.ras_miss}, {31'd0, m});
    chk({tag, " misalign"}, {31'd0, bus.misalign}, {31'd0, ma});
  endtask

  task automatic drive(input logic [1:0] sel, input logic bt, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] rs,
                       input logic lk, input logic rt, input logic st);
    bus.npc_sel  = npc_sel_e'(sel);
    bus.br_taken = bt;
    bus.imm16    = imm;
    bus.target   = tgt;
    bus.rs_val   = rs;
    bus.link     = lk;
    bus.ret      = rt;
    bus.stall    = st;
  endtask

  task automatic jr(input logic [31:0] rs, input logic lk, input logic rt);
    drive(2'd3, 1'b0, 16'h0, 26'h0, rs, lk, rt, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pushed [5];
  logic [31:0] cur_pc;

  initial begin
    // sel: 0=SEQ 1=BR 2=JMP 3=JR
    //           sel  bt   imm       tgt       rs            lk   rt   st   exp_pc        miss mis
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0004, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0008, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_000C, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h100,      0, 0, 0, 32'h0000_0100, 0, 0));
    vq.push_back(mk(1, 1, 16'hFFFE, 26'h0,  32'h0,        0, 0, 0, 32'h0000_00FC, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h100,      0, 0, 0, 32'h0000_0100, 0, 0));
    vq.push_back(mk(1, 0, 16'hFFFE, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0104, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h3000_0000,0, 0, 0, 32'h3000_0000, 0, 0));
    vq.push_back(mk(2, 0, 16'h0000, 26'h10, 32'h0,        0, 0, 0, 32'h3000_0040, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'hFFFF_FFFC,0, 0, 0, 32'hFFFF_FFFC, 0, 0));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0000, 0, 0));
    vq.push_back(mk(2, 0, 16'h0000, 26'h55, 32'h0,        1, 0, 1, 32'h0000_0000, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h202,      0, 0, 0, 32'h0000_0080, 0, 1));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0084, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h40,       0, 0, 0, 32'h0000_0040, 0, 0));
    vq.push_back(mk(2, 0, 16'h0000, 26'h10, 32'h0,        1, 0, 0, 32'h0000_0040, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h44,       0, 1, 0, 32'h0000_0044, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h48,       0, 1, 0, 32'h0000_0048, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        1, 1, 0, 32'h0000_004C, 0, 0));
    vq.push_back(mk(1, 1, 16'h0004, 26'h0,  32'h0,        0, 0, 0, 32'h0000_0060, 0, 0));
    vq.push_back(mk(2, 0, 16'h0000, 26'h40, 32'h0,        1, 0, 0, 32'h0000_0100, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h68,       0, 1, 0, 32'h0000_0068, 1, 0));
    vq.push_back(mk(0, 0, 16'h0000, 26'h0,  32'h0,        0, 0, 0, 32'h0000_006C, 0, 0));
    vq.push_back(mk(3, 0, 16'h0000, 26'h0,  32'h3,        0, 1, 1, 32'h0000_006C, 0, 0));

    drive(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_out("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].sel, vq[i].bt, vq[i].imm, vq[i].tgt, vq[i].rs, vq[i].lk, vq[i].rt, vq[i].st);
      step();
      check_out($sformatf("vec%0d", i), vq[i].exp_pc, vq[i].exp_miss, vq[i].exp_mis);
    end

    // Overflow: five pushes into a four-deep stack, four matching pops, then a miss.
    jr(32'h1000, 1'b0, 1'b0);
    step();
    check_out("ovf_start", 32'h1000, 1'b0, 1'b0);
    cur_pc = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      pushed[i] = cur_pc + 32'd4;
      cur_pc = 32'h2000 + 32'h1000 * i;
      jr(cur_pc, 1'b1, 1'b0);
      step();
      check_out($sformatf("ovf_push%0d", i), cur_pc, 1'b0, 1'b0);
    end
    for (int i = 4; i >= 1; i--) begin
      jr(pushed[i], 1'b0, 1'b1);
      step();
      check_out($sformatf("ovf_pop%0d", i), pushed[i], 1'b0, 1'b0);
    end
    jr(pushed[0], 1'b0, 1'b1);
    step();
    check_out("ovf_pop_empty", pushed[0], 1'b1, 1'b0);

    // Misaligned call still pushes; then an asynchronous reset clears everything.
    jr(32'h702, 1'b1, 1'b0);
    step();
    check_out("mis_link", 32'h80, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 1'b0, 1'b0);
    drive(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_out($sformatf("post_rst_seq%0d", i), 32'd4 * i, 1'b0, 1'b0);
    end
    jr(pushed[0] + 32'd4, 1'b0, 1'b1);
    step();
    check_out("post_rst_ret", 32'h1008, 1'b1, 1'b0);

    // Push and pop together: on empty, then on a one-entry stack.
    drive(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("pp_seq", 32'h100C, 1'b0, 1'b0);
    jr(32'h2000, 1'b1, 1'b1);
    step();
    check_out("pp_empty", 32'h2000, 1'b1, 1'b0);
    jr(32'h1010, 1'b0, 1'b1);
    step();
    check_out("pp_empty_ret", 32'h1010, 1'b0, 1'b0);
    jr(32'h3000, 1'b1, 1'b0);
    step();
    check_out("pp_call", 32'h3000, 1'b0, 1'b0);
    jr(32'h1014, 1'b1, 1'b1);
    step();
    check_out("pp_both", 32'h1014, 1'b0, 1'b0);
    jr(32'h3004, 1'b0, 1'b1);
    step();
    check_out("pp_ret_new", 32'h3004, 1'b0, 1'b0);
    jr(32'h3004, 1'b0, 1'b1);
    step();
    check_out("pp_ret_empty", 32'h3004, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
